seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed driver for a bank of common-anode 7-segment digits. It performs hex decoding (0-F) of a packed multi-digit word and scans one digit per refresh slot. It adds tear-free frame-synchronised loading, per-digit enable, decimal points, leading-zero blanking, an overload indication and an anti-ghosting blank interval. It sits between the datapath (counters, measurement results) and the board's anode/segment pins.

Parameters:
DIGITS, 8, number of digits scanned (1..16)
REFRESH_DIV, 100000, clk cycles per digit slot (>=2)
BLANK_CYCLES, 16, cycles at the start of each slot with all anodes off (0 <= BLANK_CYCLES < REFRESH_DIV)

Ports:
clk_i  in  1  system clock
rstn_i  in  1  synchronous reset, active-low
data_i  in  4*DIGITS  packed nibbles; digit k = data_i[4k+3:4k], digit 0 rightmost
dots_i  in  DIGITS  decimal point request per digit, 1 = lit
digit_en_i  in  DIGITS  per-digit enable, 0 = anode never driven
lzb_i  in  1  leading-zero blanking mode
overload_i  in  1  overload flag, captured with data
load_i  in  1  capture strobe for data_i/dots_i/overload_i
an_o  out  DIGITS  anodes, active-low, at most one low
seg_o  out  7  segments, active-low, seg_o[0]=a … seg_o[6]=g
dp_o  out  1  decimal point, active-low
frame_o  out  1  one-cycle pulse when a new frame starts

Behaviour:
- Reset (rstn_i low at clk edge): div_cnt=0, idx=0, pending and active registers (nibbles, dots, overload) = 0; an_o all 1s, seg_o=7'h7F, dp_o=1, frame_o=0. Reset overrides everything, including mid-slot and mid-frame reset.
- div_cnt counts 0..REFRESH_DIV-1 and then wraps to 0. At the wrap, idx advances and wraps from DIGITS-1 to 0.
- Frame boundary is the edge where div_cnt==REFRESH_DIV-1 and idx==DIGITS-1. At that edge, active <= (load_i ? inputs : pending), and frame_o is 1 for the following cycle.
- load_i at any other edge updates pending only. The displayed image never changes mid-frame.
- Outputs are registered: values in cycle t are computed from div_cnt/idx/active in cycle t-1 (latency 1).
- Anode:
  - an_o = all 1s when div_cnt < BLANK_CYCLES, or when digit_en_i[idx]=0.
  - Otherwise an_o[idx]=0 and all other bits are 1.
  - digit_en_i is live (not captured).
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (lzb_i=1, live):
  - Scan from digit DIGITS-1 downward. Disabled digits and zero nibbles are blanked (seg_o=7'h7F) until the first enabled non-zero nibble.
  - Digit 0 is never blanked by LZB.
  - Dots still show on LZB-blanked digits.
- Overload (active overload=1): digit 0 shows E (0000110), all other digits show 7'h7F, and every dp is off. The anode scan continues unchanged.
- During the blank interval and on disabled digits, seg_o=7'h7F and dp_o=1.
- dp_o = ~active_dots[idx], subject to the rules above.

Test Plan:
- DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1. Hold rstn_i low 3 cycles, then release.
  - During reset: an_o=4'hF, seg_o=7'h7F, dp_o=1.
  - After release: 1 blank cycle, then an_o=4'b1110 with seg_o=1000000 for 3 cycles, then digit 1, and so on.
  - frame_o pulses every 16 cycles.
- Load data_i=16'hA5C9 at a frame boundary. Required segments per slot:
  - digit0 = 0010000
  - digit1 = 1000110
  - digit2 = 0010010
  - digit3 = 0001000
- Assert load_i with 16'h1234 while idx=1, mid-frame.
  - Digits 1-3 keep their old values for the rest of the frame.
  - 1234 appears only after the next frame_o pulse.
- lzb_i=1, data 16'h0070.
  - Digits 3 and 2 show 7'h7F.
  - Digit 1 shows 1111000; digit 0 shows 1000000.
  - With 16'h0000, only digit 0 shows 0.
- Load overload_i=1 with dots_i=4'hF.
  - Digit 0 shows 0000110; others show 7'h7F.
  - dp_o stays 1 throughout.
- digit_en_i=4'b1011: an_o never drives digit 2 low, but its slot time is still consumed. Pull rstn_i low mid-slot at idx=2: outputs reach reset values next cycle and the scan restarts at digit 0.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex driver for a bank of common-anode 7-segment digits.
// The displayed image is swapped only at frame boundaries, so a frame never mixes old and new data.
module seg7_scan_driver #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [4*DIGITS-1:0]   data_i,
  input  logic [DIGITS-1:0]     dots_i,
  input  logic [DIGITS-1:0]     digit_en_i,
  input  logic                  lzb_i,
  input  logic                  overload_i,
  input  logic                  load_i,
  output logic [DIGITS-1:0]     an_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  frame_o
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [6:0]       SEG_OFF   = 7'h7F;
  localparam logic [6:0]       SEG_E     = 7'b0000110;

  // Active-low gfedcba hex glyphs
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [CNT_W-1:0]        div_cnt;
  logic [IDX_W-1:0]        idx;
  logic [DIGITS-1:0][3:0]  pend_nib;
  logic [DIGITS-1:0][3:0]  act_nib;
  logic [DIGITS-1:0]       pend_dots;
  logic [DIGITS-1:0]       act_dots;
  logic                    pend_ovl;
  logic                    act_ovl;

  logic                    slot_end;
  logic                    frame_end;
  logic                    in_blank;
  logic [DIGITS-1:0]       lead_blank;
  logic                    lzb_run;
  logic [DIGITS-1:0]       an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  assign slot_end  = (div_cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);
  assign in_blank  = (div_cnt < CNT_BLANK);

  // lead_blank[k]: every digit from the top down to k is disabled or zero
  always_comb begin
    lead_blank = '0;
    lzb_run    = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      lzb_run       = lzb_run & (~digit_en_i[i] | (act_nib[i] == 4'h0));
      lead_blank[i] = lzb_run;
    end
  end

  // Next-cycle anode/segment/dp values for the current slot
  always_comb begin
    an_nxt  = '1;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    if (!in_blank && digit_en_i[idx]) begin
      an_nxt[idx] = 1'b0;
      if (act_ovl) begin
        seg_nxt = (idx == '0) ? SEG_E : SEG_OFF;
      end else begin
        if (lzb_i && (idx != '0) && lead_blank[idx]) begin
          seg_nxt = SEG_OFF;
        end else begin
          seg_nxt = hex_to_seg(act_nib[idx]);
        end
        dp_nxt = ~act_dots[idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      div_cnt   <= '0;
      idx       <= '0;
      pend_nib  <= '0;
      act_nib   <= '0;
      pend_dots <= '0;
      act_dots  <= '0;
      pend_ovl  <= 1'b0;
      act_ovl   <= 1'b0;
      an_o      <= '1;
      seg_o     <= SEG_OFF;
      dp_o      <= 1'b1;
      frame_o   <= 1'b0;
    end else begin
      div_cnt <= slot_end ? '0 : div_cnt + CNT_W'(1);
      if (slot_end) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end
      if (load_i) begin
        pend_nib  <= data_i;
        pend_dots <= dots_i;
        pend_ovl  <= overload_i;
      end
      // A strobe coinciding with the boundary goes straight to the display
      if (frame_end) begin
        act_nib  <= load_i ? data_i     : pend_nib;
        act_dots <= load_i ? dots_i     : pend_dots;
        act_ovl  <= load_i ? overload_i : pend_ovl;
      end
      an_o    <= an_nxt;
      seg_o   <= seg_nxt;
      dp_o    <= dp_nxt;
      frame_o <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with 4 digits, 4-cycle slots and 1 blank cycle.
module tb_seg7_scan_driver;

  localparam int unsigned DIGITS = 4;

  logic              clk = 1'b0;
  logic              rstn_i;
  logic [15:0]       data_i;
  logic [3:0]        dots_i;
  logic [3:0]        digit_en_i;
  logic              lzb_i;
  logic              overload_i;
  logic              load_i;
  logic [3:0]        an_o;
  logic [6:0]        seg_o;
  logic              dp_o;
  logic              frame_o;

  int checks   = 0;
  int failures = 0;

  seg7_scan_driver #(
    .DIGITS       (DIGITS),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .data_i     (data_i),
    .dots_i     (dots_i),
    .digit_en_i (digit_en_i),
    .lzb_i      (lzb_i),
    .overload_i (overload_i),
    .load_i     (load_i),
    .an_o       (an_o),
    .seg_o      (seg_o),
    .dp_o       (dp_o),
    .frame_o    (frame_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One 4-cycle slot: blank cycle then three lit cycles
  task automatic check_slot(input int d, input logic [6:0] seg, input logic dp, input logic en);
    logic [3:0] an_exp;
    an_exp = 4'hF;
    if (en) an_exp[d] = 1'b0;
    tick;
    chk($sformatf("d%0d_blank_an", d), an_o, 4'hF);
    chk($sformatf("d%0d_blank_seg", d), seg_o, 7'h7F);
    chk($sformatf("d%0d_blank_dp", d), dp_o, 1'b1);
    chk($sformatf("d%0d_frame_low", d), frame_o, 1'b0);
    for (int j = 0; j < 3; j++) begin
      tick;
      chk($sformatf("d%0d_an", d), an_o, an_exp);
      chk($sformatf("d%0d_seg", d), seg_o, en ? seg : 7'h7F);
      chk($sformatf("d%0d_dp", d), dp_o, en ? dp : 1'b1);
    end
  endtask

  task automatic check_frame(input logic [3:0][6:0] segs, input logic [3:0] dpl, input logic [3:0] en);
    for (int d = 0; d < 4; d++) check_slot(d, segs[d], dpl[d], en[d]);
    chk("frame_pulse", frame_o, 1'b1);
  endtask

  // Called just after a frame pulse; strobes pending, then runs to the next pulse
  task automatic stage(input logic [15:0] data, input logic [3:0] dots, input logic ovl);
    data_i = data; dots_i = dots; overload_i = ovl; load_i = 1'b1;
    tick;
    load_i = 1'b0;
    repeat (15) tick;
    chk("stage_frame", frame_o, 1'b1);
  endtask

  // Leaves the bench one edge before a frame boundary
  task automatic goto_boundary;
    int n;
    n = 0;
    do begin
      tick;
      n++;
    end while (frame_o !== 1'b1 && n < 64);
    chk("frame_found", frame_o, 1'b1);
    repeat (15) tick;
  endtask

  initial begin
    logic [3:0] exp_an;
    int n;
    rstn_i = 1'b0; data_i = '0; dots_i = '0; digit_en_i = 4'hF;
    lzb_i = 1'b0; overload_i = 1'b0; load_i = 1'b0;

    repeat (3) begin
      tick;
      chk("rst_an", an_o, 4'hF);
      chk("rst_seg", seg_o, 7'h7F);
      chk("rst_dp", dp_o, 1'b1);
      chk("rst_frame", frame_o, 1'b0);
    end
    rstn_i = 1'b1;

    // First frame after reset: all-zero image, scan order and frame pulse
    for (int k = 1; k <= 16; k++) begin
      tick;
      n = k - 1;
      exp_an = 4'hF;
      if ((n % 4) != 0) exp_an[n / 4] = 1'b0;
      chk("scan_an", an_o, exp_an);
      chk("scan_seg", seg_o, ((n % 4) == 0) ? 7'h7F : 7'b1000000);
      chk("scan_frame", frame_o, k == 16);
    end

    // Load exactly on a boundary edge
    goto_boundary;
    data_i = 16'hA5C9; dots_i = 4'b0101; load_i = 1'b1;
    tick;
    load_i = 1'b0;
    chk("boundary_frame", frame_o, 1'b1);
    check_frame({7'b0001000, 7'b0010010, 7'b1000110, 7'b0010000}, 4'b1010, 4'hF);

    // Mid-frame load while idx=1 must not tear the current frame
    check_slot(0, 7'b0010000, 1'b0, 1'b1);
    data_i = 16'h1234; dots_i = 4'b0000; load_i = 1'b1;
    tick;
    load_i = 1'b0;
    chk("mid_blank_an", an_o, 4'hF);
    for (int j = 0; j < 3; j++) begin
      tick;
      chk("mid_d1_an", an_o, 4'b1101);
      chk("mid_d1_seg", seg_o, 7'b1000110);
    end
    check_slot(2, 7'b0010010, 1'b0, 1'b1);
    check_slot(3, 7'b0001000, 1'b1, 1'b1);
    chk("mid_frame", frame_o, 1'b1);
    check_frame({7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}, 4'hF, 4'hF);

    // Leading-zero blanking
    lzb_i = 1'b1;
    stage(16'h0070, 4'b0000, 1'b0);
    check_frame({7'h7F, 7'h7F, 7'b1111000, 7'b1000000}, 4'hF, 4'hF);
    stage(16'h0000, 4'b1000, 1'b0);
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b0111, 4'hF);
    digit_en_i = 4'b0111;
    stage(16'h5070, 4'b0000, 1'b0);
    check_frame({7'h7F, 7'h7F, 7'b1111000, 7'b1000000}, 4'hF, 4'b0111);
    digit_en_i = 4'hF;
    lzb_i = 1'b0;

    // Overload
    stage(16'h1234, 4'hF, 1'b1);
    check_frame({7'h7F, 7'h7F, 7'h7F, 7'b0000110}, 4'hF, 4'hF);

    // Disabled digit 2, then reset in the middle of its slot
    digit_en_i = 4'b1011;
    stage(16'hA5C9, 4'b0000, 1'b0);
    check_frame({7'b0001000, 7'b0010010, 7'b1000110, 7'b0010000}, 4'hF, 4'b1011);
    check_slot(0, 7'b0010000, 1'b1, 1'b1);
    check_slot(1, 7'b1000110, 1'b1, 1'b1);
    tick;
    tick;
    chk("d2_disabled_an", an_o, 4'hF);
    rstn_i = 1'b0;
    tick;
    chk("midrst_an", an_o, 4'hF);
    chk("midrst_seg", seg_o, 7'h7F);
    chk("midrst_dp", dp_o, 1'b1);
    chk("midrst_frame", frame_o, 1'b0);
    rstn_i = 1'b1;
    check_slot(0, 7'b1000000, 1'b1, 1'b1);
    check_slot(1, 7'b1000000, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
